// File: rtl/brnch_ctrl_pkg.sv
// brnch_ctrl_pkg: branch-type encodings and controller state codes
package brnch_ctrl_pkg;
    typedef enum logic [1:0] {BR_EQZ = 2'b00, BR_NEZ = 2'b01, BR_LTZ = 2'b10, BR_GEZ = 2'b11} br_typ_e;
    typedef enum logic [1:0] {IDLE = 2'b00, WAIT_FLG = 2'b01, REDIR = 2'b10, FLUSH = 2'b11} state_e;
endpackage

// File: rtl/brnch_checker.sv
// brnch_checker: evaluates a branch condition from ALU zero/neg flags
module brnch_checker
    import brnch_ctrl_pkg::*;
(
    input  logic [1:0] typ_i,
    input  logic       zero_i,
    input  logic       neg_i,
    output logic       taken_o
);
    always_comb taken_o = typ_i == BR_EQZ ? zero_i :
                          typ_i == BR_NEZ ? !zero_i :
                          typ_i == BR_LTZ ? neg_i : (zero_i || !neg_i);
endmodule

// File: rtl/brnch_ctrl.sv
// brnch_ctrl: sequences branch resolution, PC redirect, fetch flush and saturating branch stats
module brnch_ctrl
    import brnch_ctrl_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid_i,
    input  logic [1:0]       br_typ_i,
    input  logic [PC_W-1:0]  br_tgt_i,
    output logic             br_ready_o,
    input  logic             flg_valid_i,
    input  logic             zero_i,
    input  logic             neg_i,
    output logic             pc_redir_en_o,
    output logic [PC_W-1:0]  pc_redir_o,
    output logic             flush_o,
    output logic             fetch_stall_o,
    input  logic             clr_stats_i,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);
    state_e           state_q;
    logic [1:0]       typ_q;
    logic [PC_W-1:0]  tgt_q;
    logic [2:0]       fcnt_q;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, taken_cnt_q, taken_cnt_d;
    logic             taken, resolve;

    brnch_checker u_chk (.typ_i(typ_q), .zero_i(zero_i), .neg_i(neg_i), .taken_o(taken));

    assign resolve     = state_q == WAIT_FLG && flg_valid_i;
    assign br_ready_o  = state_q == IDLE;
    assign br_cnt_o    = br_cnt_q;
    assign taken_cnt_o = taken_cnt_q;

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        br_cnt_d    = clr_stats_i ? '0 : (resolve && !(&br_cnt_q)) ? br_cnt_q + CNT_W'(1) : br_cnt_q;
        taken_cnt_d = clr_stats_i ? '0 : (resolve && taken && !(&taken_cnt_q)) ? taken_cnt_q + CNT_W'(1) : taken_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Redirect/flush/stall are set on entry to each state so they are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            typ_q         <= '0;
            tgt_q         <= '0;
            fcnt_q        <= '0;
            pc_redir_en_o <= 1'b0;
            pc_redir_o    <= '0;
            flush_o       <= 1'b0;
            fetch_stall_o <= 1'b0;
        end else begin
            pc_redir_en_o <= 1'b0;
            fetch_stall_o <= 1'b0;
            case (state_q)
                IDLE: if (br_valid_i) begin
                    typ_q   <= br_typ_i;
                    tgt_q   <= br_tgt_i;
                    state_q <= WAIT_FLG;
                end
                WAIT_FLG: if (flg_valid_i) begin
                    if (taken) begin
                        state_q       <= REDIR;
                        pc_redir_en_o <= 1'b1;
                        pc_redir_o    <= tgt_q;
                        flush_o       <= 1'b1;
                        fetch_stall_o <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REDIR: begin
                    fcnt_q  <= 3'(FLUSH_CYC - 1);
                    state_q <= FLUSH_CYC > 1 ? FLUSH : IDLE;
                    flush_o <= FLUSH_CYC > 1;
                end
                FLUSH: begin
                    fcnt_q <= fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) begin
                        state_q <= IDLE;
                        flush_o <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_brnch_ctrl.sv
// tb_brnch_ctrl: directed bench for brnch_ctrl with a redirect-target scoreboard
module tb_brnch_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        br_valid = 1'b0, flg_valid = 1'b0, zero = 1'b0, neg = 1'b0, clr_stats = 1'b0;
    logic [1:0]  br_typ = 2'd0;
    logic [15:0] br_tgt = 16'd0;
    logic        br_ready, pc_redir_en, flush, fetch_stall;
    logic [15:0] pc_redir, br_cnt, taken_cnt;
    int          n_cmp = 0, n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m_br = 16'd0, m_tk = 16'd0;

    always #5 clk = ~clk;

    brnch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .br_valid_i(br_valid), .br_typ_i(br_typ), .br_tgt_i(br_tgt),
        .br_ready_o(br_ready), .flg_valid_i(flg_valid), .zero_i(zero), .neg_i(neg),
        .pc_redir_en_o(pc_redir_en), .pc_redir_o(pc_redir), .flush_o(flush),
        .fetch_stall_o(fetch_stall), .clr_stats_i(clr_stats), .br_cnt_o(br_cnt), .taken_cnt_o(taken_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_tk(input logic [1:0] t, input logic z, input logic n);
        case (t)
            2'd0: return z;
            2'd1: return !z;
            2'd2: return n;
            default: return z || !n;
        endcase
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Every redirect pulse must match the oldest pending taken target.
    always @(negedge clk) begin
        if (rst_n && pc_redir_en) begin
            if (exp_q.size() == 0) chk("redir_unexpected", pc_redir_en, 1'b0);
            else chk("redir_tgt", pc_redir, exp_q.pop_front());
        end
    end

    task automatic flg_pulse(input logic [1:0] typ, input logic [15:0] tgt, input logic z, input logic n,
                             input logic clr, output logic tk);
        flg_valid = 1'b1; zero = z; neg = n; clr_stats = clr;
        tk = model_tk(typ, z, n);
        if (tk) exp_q.push_back(tgt);
        m_br = clr ? 16'd0 : sat(m_br);
        m_tk = clr ? 16'd0 : tk ? sat(m_tk) : m_tk;
        step;
        flg_valid = 1'b0; clr_stats = 1'b0;
    endtask

    task automatic run_br(input logic [1:0] typ, input logic [15:0] tgt, input logic z, input logic n,
                          input logic clr);
        logic tk;
        for (int i = 0; i < 20 && !br_ready; i++) step;
        chk("ready_wait", br_ready, 1'b1);
        br_valid = 1'b1; br_typ = typ; br_tgt = tgt;
        step;
        br_valid = 1'b0;
        chk("accept_busy", br_ready, 1'b0);
        step;
        flg_pulse(typ, tgt, z, n, clr, tk);
        chk("redir_en", pc_redir_en, tk);
        chk("flush_redir", flush, tk);
        chk("stall_redir", fetch_stall, tk);
        chk("ready_after_flg", br_ready, !tk);
        chk("br_cnt", br_cnt, m_br);
        chk("taken_cnt", taken_cnt, m_tk);
        if (tk) begin
            step;
            chk("flush_hold", flush, 1'b1);
            chk("stall_drop", fetch_stall, 1'b0);
            chk("redir_drop", pc_redir_en, 1'b0);
            chk("ready_flush", br_ready, 1'b0);
            step;
            chk("flush_end", flush, 1'b0);
            chk("ready_end", br_ready, 1'b1);
            chk("redir_hold", pc_redir, tgt);
        end
    endtask

    initial begin
        logic tk;
        #12;
        chk("rst_ready", br_ready, 1'b1);
        chk("rst_redir_en", pc_redir_en, 1'b0);
        chk("rst_flush", flush, 1'b0);
        chk("rst_stall", fetch_stall, 1'b0);
        chk("rst_pc", pc_redir, 16'h0);
        chk("rst_br_cnt", br_cnt, 16'h0);
        rst_n = 1'b1;
        step;
        flg_valid = 1'b1; zero = 1'b1;
        step;
        flg_valid = 1'b0;
        chk("idle_flg_ignored", br_cnt, 16'h0);
        run_br(2'b00, 16'h0040, 1'b1, 1'b0, 1'b0);
        run_br(2'b11, 16'h0050, 1'b0, 1'b1, 1'b0);
        // Second branch held through the first's redirect and flush.
        br_valid = 1'b1; br_typ = 2'b00; br_tgt = 16'h0080;
        step;
        br_tgt = 16'h0100;
        chk("held_busy_wait", br_ready, 1'b0);
        step;
        flg_pulse(2'b00, 16'h0080, 1'b1, 1'b0, 1'b0, tk);
        chk("held_busy_redir", br_ready, 1'b0);
        step;
        chk("held_busy_flush", br_ready, 1'b0);
        step;
        chk("held_idle", br_ready, 1'b1);
        step;
        chk("held_accepted", br_ready, 1'b0);
        br_valid = 1'b0;
        step;
        flg_pulse(2'b00, 16'h0100, 1'b1, 1'b0, 1'b0, tk);
        chk("held_redir_en", pc_redir_en, 1'b1);
        chk("held_redir_pc", pc_redir, 16'h0100);
        chk("held_br_cnt", br_cnt, m_br);
        step;
        step;
        // Reset dropped while flushing.
        br_valid = 1'b1; br_typ = 2'b01; br_tgt = 16'h0200;
        step;
        br_valid = 1'b0;
        step;
        flg_pulse(2'b01, 16'h0200, 1'b0, 1'b0, 1'b0, tk);
        step;
        chk("pre_rst_flush", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_flush", flush, 1'b0);
        chk("mid_rst_stall", fetch_stall, 1'b0);
        chk("mid_rst_redir_en", pc_redir_en, 1'b0);
        chk("mid_rst_ready", br_ready, 1'b1);
        chk("mid_rst_br_cnt", br_cnt, 16'h0);
        chk("mid_rst_taken_cnt", taken_cnt, 16'h0);
        m_br = 16'd0; m_tk = 16'd0;
        step;
        rst_n = 1'b1;
        step;
        // Saturation from a preloaded value, then clear racing an increment.
        force dut.br_cnt_q = 16'hFFFE;
        force dut.taken_cnt_q = 16'hFFFE;
        #1;
        release dut.br_cnt_q;
        release dut.taken_cnt_q;
        m_br = 16'hFFFE; m_tk = 16'hFFFE;
        for (int i = 0; i < 3; i++) run_br(2'b10, 16'h0300 + 16'(i), 1'b0, 1'b1, 1'b0);
        chk("sat_br_cnt", br_cnt, 16'hFFFF);
        chk("sat_taken_cnt", taken_cnt, 16'hFFFF);
        run_br(2'b10, 16'h0400, 1'b0, 1'b1, 1'b1);
        chk("clr_br_cnt", br_cnt, 16'h0);
        chk("clr_taken_cnt", taken_cnt, 16'h0);
        for (int t = 0; t < 4; t++)
            for (int zn = 0; zn < 4; zn++)
                run_br(2'(t), 16'h1000 + 16'(t * 16 + zn), zn[1], zn[0], 1'b0);
        step;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
